// File: rtl/face_det_pkg.sv
// Shared face-detection types and constants.
// Used by the integral image front end and the classifier.
package face_det_pkg;

   localparam int DEF_IMG_W = 20;
   localparam int DEF_IMG_H = 20;
   localparam int DEF_II_W  = 32;

   localparam logic [7:0] LUMA_R     = 8'd77;
   localparam logic [7:0] LUMA_G     = 8'd150;
   localparam logic [7:0] LUMA_B     = 8'd29;
   localparam int         LUMA_SHIFT = 8;

   typedef logic [DEF_II_W-1:0] ii_t;
   typedef logic [7:0]          gray_t;

endpackage

// File: rtl/rgb_to_gray.sv
// Combinational luma: weights sum to 256 so the shifted
// result always fits 8 bits.
module rgb_to_gray
   import face_det_pkg::*;
(
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   output gray_t      gray
);

   logic [15:0] sum;

   assign sum = 16'(r) * 16'(LUMA_R)
              + 16'(g) * 16'(LUMA_G)
              + 16'(b) * 16'(LUMA_B);

   assign gray = gray_t'(sum >> LUMA_SHIFT);

endmodule

// File: rtl/integral_image_builder.sv
// Raster-order integral image: gray stage, then running
// row sum plus the line buffer entry from the row above.
module integral_image_builder
   import face_det_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int II_W  = DEF_II_W
)(
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     PIX_VALID,
   output logic                     PIX_READY,
   input  logic                     PIX_SOF,
   input  logic [7:0]               VGA_R_in,
   input  logic [7:0]               VGA_G_in,
   input  logic [7:0]               VGA_B_in,
   output logic                     II_VALID,
   input  logic                     II_READY,
   output logic [II_W-1:0]          II_DATA,
   output logic [$clog2(IMG_W)-1:0] II_X,
   output logic [$clog2(IMG_H)-1:0] II_Y,
   output logic                     II_EOF,
   output logic                     SOF_ERR
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic advance;
   logic accept;

   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic          last_col;
   logic          last_row;
   logic          sof_err_q;

   gray_t gray_c;

   logic          s1_valid;
   gray_t         s1_gray;
   logic [XW-1:0] s1_x;
   logic [YW-1:0] s1_y;
   logic          s1_eof;

   logic [II_W-1:0] rowsum_q;
   logic [II_W-1:0] rowsum_new;
   logic [II_W-1:0] lb_term;
   logic [II_W-1:0] ii_c;
   logic [II_W-1:0] linebuf [IMG_W];

   logic            ii_valid_q;
   logic [II_W-1:0] ii_data_q;
   logic [XW-1:0]   ii_x_q;
   logic [YW-1:0]   ii_y_q;
   logic            ii_eof_q;

   assign advance   = !ii_valid_q || II_READY;
   assign PIX_READY = !RESET && advance;
   assign accept    = PIX_VALID && PIX_READY;

   rgb_to_gray u_gray (
      .r    (VGA_R_in),
      .g    (VGA_G_in),
      .b    (VGA_B_in),
      .gray (gray_c)
   );

   // SOF overrides the counters for the pixel it rides on
   always_comb begin
      px       = PIX_SOF ? '0 : x_cnt;
      py       = PIX_SOF ? '0 : y_cnt;
      last_col = (px == XW'(IMG_W - 1));
      last_row = (py == YW'(IMG_H - 1));
      nx       = last_col ? '0 : px + 1'b1;
      ny       = py;
      if (last_col) begin
         ny = last_row ? '0 : py + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         x_cnt     <= '0;
         y_cnt     <= '0;
         sof_err_q <= 1'b0;
         s1_valid  <= 1'b0;
         s1_gray   <= '0;
         s1_x      <= '0;
         s1_y      <= '0;
         s1_eof    <= 1'b0;
      end else begin
         sof_err_q <= accept && PIX_SOF
                   && (x_cnt != '0 || y_cnt != '0);
         if (accept) begin
            x_cnt <= nx;
            y_cnt <= ny;
         end
         if (advance) begin
            s1_valid <= accept;
            s1_gray  <= gray_c;
            s1_x     <= px;
            s1_y     <= py;
            s1_eof   <= last_col && last_row;
         end
      end
   end

   // Row 0 never reads the line buffer, so it needs no reset
   always_comb begin
      rowsum_new = (s1_x == '0) ? II_W'(s1_gray)
                                : rowsum_q + II_W'(s1_gray);
      lb_term    = (s1_y == '0) ? '0 : linebuf[s1_x];
      ii_c       = rowsum_new + lb_term;
   end

   always_ff @(posedge CLK) begin
      if (advance && s1_valid) begin
         linebuf[s1_x] <= ii_c;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rowsum_q   <= '0;
         ii_valid_q <= 1'b0;
         ii_data_q  <= '0;
         ii_x_q     <= '0;
         ii_y_q     <= '0;
         ii_eof_q   <= 1'b0;
      end else if (advance) begin
         ii_valid_q <= s1_valid;
         if (s1_valid) begin
            rowsum_q  <= rowsum_new;
            ii_data_q <= ii_c;
            ii_x_q    <= s1_x;
            ii_y_q    <= s1_y;
            ii_eof_q  <= s1_eof;
         end
      end
   end

   assign II_VALID = ii_valid_q;
   assign II_DATA  = ii_data_q;
   assign II_X     = ii_x_q;
   assign II_Y     = ii_y_q;
   assign II_EOF   = ii_eof_q;
   assign SOF_ERR  = sof_err_q;

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for the integral image builder with a
// rectangle-sum reference and an output scoreboard.
module tb_integral_image_builder;

   localparam int W = 20;
   localparam int H = 20;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        PIX_VALID = 1'b0;
   logic        PIX_READY;
   logic        PIX_SOF = 1'b0;
   logic [7:0]  VGA_R_in = '0;
   logic [7:0]  VGA_G_in = '0;
   logic [7:0]  VGA_B_in = '0;
   logic        II_VALID;
   logic        II_READY = 1'b1;
   logic [31:0] II_DATA;
   logic [4:0]  II_X;
   logic [4:0]  II_Y;
   logic        II_EOF;
   logic        SOF_ERR;

   integral_image_builder dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .PIX_VALID (PIX_VALID),
      .PIX_READY (PIX_READY),
      .PIX_SOF   (PIX_SOF),
      .VGA_R_in  (VGA_R_in),
      .VGA_G_in  (VGA_G_in),
      .VGA_B_in  (VGA_B_in),
      .II_VALID  (II_VALID),
      .II_READY  (II_READY),
      .II_DATA   (II_DATA),
      .II_X      (II_X),
      .II_Y      (II_Y),
      .II_EOF    (II_EOF),
      .SOF_ERR   (SOF_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] data;
      int          x;
      int          y;
      bit          eof;
   } exp_t;

   exp_t        q[$];
   int          gref [H][W];
   int          mx, my, n_acc;
   bit          exp_sof_err;
   bit          held;
   logic [31:0] held_data;
   logic [9:0]  held_xy;
   logic        held_eof;
   logic [31:0] last_data;
   int          last_x, last_y;
   bit          last_eof;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_accept(input int r, input int g,
                               input int b, input bit sof);
      exp_t e;
      int   s;
      if (sof) begin
         if (mx != 0 || my != 0) exp_sof_err = 1'b1;
         mx = 0;
         my = 0;
      end
      gref[my][mx] = (77 * r + 150 * g + 29 * b) >> 8;
      s = 0;
      for (int yy = 0; yy <= my; yy++)
         for (int xx = 0; xx <= mx; xx++)
            s += gref[yy][xx];
      e.data = s;
      e.x    = mx;
      e.y    = my;
      e.eof  = (mx == W - 1) && (my == H - 1);
      q.push_back(e);
      n_acc++;
      if (mx == W - 1) begin
         mx = 0;
         my = (my == H - 1) ? 0 : my + 1;
      end else begin
         mx = mx + 1;
      end
   endtask

   task automatic cycle(input bit pv, input int r,
                        input int g, input int b,
                        input bit sof, input bit ordy);
      exp_t e;
      @(negedge CLK);
      PIX_VALID = pv;
      PIX_SOF   = sof;
      VGA_R_in  = 8'(r);
      VGA_G_in  = 8'(g);
      VGA_B_in  = 8'(b);
      II_READY  = ordy;
      #1;
      chk("sof_err", 32'(SOF_ERR), 32'(exp_sof_err));
      exp_sof_err = 1'b0;
      if (held) begin
         chk("hold_valid", 32'(II_VALID), 32'd1);
         chk("hold_data", II_DATA, held_data);
         chk("hold_xy", 32'({II_X, II_Y}), 32'(held_xy));
         chk("hold_eof", 32'(II_EOF), 32'(held_eof));
      end
      if (II_VALID && II_READY) begin
         if (q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("ii_data", II_DATA, e.data);
            chk("ii_x", 32'(II_X), 32'(e.x));
            chk("ii_y", 32'(II_Y), 32'(e.y));
            chk("ii_eof", 32'(II_EOF), 32'(e.eof));
         end
         last_data = II_DATA;
         last_x    = int'(II_X);
         last_y    = int'(II_Y);
         last_eof  = II_EOF;
      end
      held      = II_VALID && !II_READY;
      held_data = II_DATA;
      held_xy   = {II_X, II_Y};
      held_eof  = II_EOF;
      if (PIX_VALID && PIX_READY)
         model_accept(r, g, b, sof);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (q.size() == 0) break;
         cycle(0, 0, 0, 0, 0, 1);
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET     = 1'b1;
      PIX_VALID = 1'b0;
      PIX_SOF   = 1'b0;
      II_READY  = 1'b1;
      #1;
      chk("rst_pix_ready", 32'(PIX_READY), 32'd0);
      @(negedge CLK);
      chk("rst_valid", 32'(II_VALID), 32'd0);
      chk("rst_data", II_DATA, 32'd0);
      chk("rst_xy", 32'({II_X, II_Y}), 32'd0);
      chk("rst_eof", 32'(II_EOF), 32'd0);
      chk("rst_sof_err", 32'(SOF_ERR), 32'd0);
      chk("rst_pix_ready2", 32'(PIX_READY), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      q.delete();
      mx          = 0;
      my          = 0;
      exp_sof_err = 1'b0;
      held        = 1'b0;
   endtask

   initial begin
      int v;
      int cyc;

      do_reset();

      // single red pixel, latency two
      cycle(1, 255, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);
      chk("lat_1cyc_invalid", 32'(II_VALID), 32'd0);
      cycle(0, 0, 0, 0, 0, 1);
      chk("single_data", last_data, 32'd76);
      chk("single_xy", 32'(last_x + last_y), 32'd0);

      // all-white frame
      do_reset();
      for (int i = 0; i < W * H; i++)
         cycle(1, 255, 255, 255, i == 0, 1);
      drain();
      chk("white_final", last_data, 32'd102000);
      chk("white_eof", 32'(last_eof), 32'd1);

      // back-to-back frame without SOF
      cycle(1, 255, 255, 255, 0, 1);
      drain();
      chk("b2b_first", last_data, 32'd255);
      chk("b2b_x", 32'(last_x), 32'd0);
      chk("b2b_y", 32'(last_y), 32'd0);
      for (int i = 1; i < W * H; i++)
         cycle(1, 255, 255, 255, 0, 1);
      drain();
      chk("b2b_final", last_data, 32'd102000);

      // gradient frame with random stalls on both sides
      do_reset();
      n_acc = 0;
      cyc   = 0;
      while (n_acc < W * H && cyc < 5000) begin
         v = (mx + 20 * my) & 255;
         cycle($urandom_range(0, 9) < 7, v, v, v, n_acc == 0,
               $urandom_range(0, 9) < 6);
         cyc++;
      end
      chk("grad_accepted", 32'(n_acc), 32'(W * H));
      drain();
      chk("grad_eof", 32'(last_eof), 32'd1);

      // SOF mid-frame at (7,3)
      do_reset();
      for (int i = 0; i < 67; i++)
         cycle(1, 255, 255, 255, i == 0, 1);
      chk("pre_sof_pos", 32'(mx + 100 * my), 32'd307);
      cycle(1, 100, 100, 100, 1, 1);
      cycle(1, 10, 10, 10, 0, 1);
      chk("sof_err_pulse", 32'(SOF_ERR), 32'd1);
      cycle(1, 10, 10, 10, 0, 1);
      chk("sof_err_once", 32'(SOF_ERR), 32'd0);
      drain();
      chk("sof_mid_last", last_data, 32'd120);

      // reset with pixels in flight
      do_reset();
      for (int i = 0; i < 5; i++)
         cycle(1, 255, 255, 255, i == 0, 1);
      do_reset();
      cycle(1, 50, 50, 50, 0, 1);
      drain();
      chk("post_rst_data", last_data, 32'd50);
      chk("post_rst_x", 32'(last_x), 32'd0);
      chk("post_rst_y", 32'(last_y), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/integral_image_builder.md
Name: integral_image_builder

Overview:
- Streaming front end of the face-detection path.
- Converts incoming VGA RGB pixels to 8-bit grayscale and computes the running integral image in raster order: ii(x,y) = sum of gray over columns 0..x and rows 0..y.
- Emits one integral value per accepted pixel, with coordinates, to the classifier stage over a valid/ready handshake.
- Sits between the camera/VGA pixel source and the classifier window logic.

Parameters:
- IMG_W, 20, frame width in pixels (row length).
- IMG_H, 20, frame height in rows.
- II_W, 32, integral value width; arithmetic wraps modulo 2^II_W.

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- PIX_VALID  in  1  input pixel valid.
- PIX_READY  out  1  block can accept a pixel this cycle.
- PIX_SOF  in  1  accepted pixel is (0,0) of a new frame.
- VGA_R_in  in  8  red component.
- VGA_G_in  in  8  green component.
- VGA_B_in  in  8  blue component.
- II_VALID  out  1  integral output valid.
- II_READY  in  1  downstream accepts the output.
- II_DATA  out  II_W  integral value ii(x,y).
- II_X  out  $clog2(IMG_W)  column of II_DATA.
- II_Y  out  $clog2(IMG_H)  row of II_DATA.
- II_EOF  out  1  II_DATA is (IMG_W-1, IMG_H-1).
- SOF_ERR  out  1  one-cycle pulse: PIX_SOF arrived mid-frame.

Behaviour:
- Reset state: II_VALID=0, II_DATA=0, II_X=0, II_Y=0, II_EOF=0, SOF_ERR=0. Column and row counters are 0, and stage-1 valid is cleared. The line buffer is not cleared; row 0 never reads it.
- PIX_READY: forced to 0 while RESET=1. Otherwise PIX_READY = advance, where advance = !II_VALID || II_READY.
- A pixel is accepted when PIX_VALID && PIX_READY.
- Pipeline: two register stages, both enabled by advance. When advance=0, every register holds, including the outputs.
- Stage 1 (gray): gray = (77*R + 150*G + 29*B) >> 8. The sum is computed in 16 bits; the result lies in 0..255. Stage 1 also registers x, y, eof and valid for the accepted pixel.
- Stage 2 (integral):
  - rowsum register: reset to gray at x=0, otherwise rowsum + gray.
  - ii = (rowsum_new + linebuf[x]) mod 2^II_W. If y=0, the line buffer term is 0.
  - linebuf[x] <= ii.
  - The output registers load ii, x, y, eof and valid.
- Latency: an accepted pixel appears on II_* exactly 2 cycles later if there is no backpressure. Each stall cycle adds one cycle. One result per cycle sustained.
- Coordinates: x increments on each accept. At x=IMG_W-1, x wraps to 0 and y increments. At (IMG_W-1, IMG_H-1), both wrap to 0. A new frame therefore starts automatically without PIX_SOF.
- PIX_SOF on an accepted pixel forces that pixel to (0,0), whatever the counter state.
  - If the counters were not already at (0,0), SOF_ERR pulses for one cycle, aligned with the accept cycle + 1.
  - The partial frame already emitted is not retracted.
- PIX_SOF with PIX_VALID=0, or while PIX_READY=0, is ignored.
- Output stability: while II_VALID=1 and II_READY=0, II_* must hold stable.
- Reset mid-frame: the in-flight pixels are discarded. The next accepted pixel is (0,0).
- No saturation. With the defaults, the maximum value is 255*400 = 102000, well within II_W.

Decomposition:
- Package face_det_pkg:
  - IMG_W and IMG_H defaults.
  - II_W.
  - Luma coefficients 77/150/29 and shift 8.
  - typedef ii_t (logic [II_W-1:0]).
  - typedef gray_t (logic [7:0]).
  - Shared with the classifier.
- Sub-module rgb_to_gray: combinational luma, R/G/B in, gray_t out. It is instantiated before the stage-1 register.
- Line buffer: an IMG_W x II_W register array inside this block. It is read and written at the same x in stage 2, read-before-write.

Test Plan:
- Single pixel: reset, then accept R=255,G=0,B=0 with SOF -> 2 cycles later II_VALID=1, II_DATA=76, II_X=0, II_Y=0.
- All-white frame: R=G=B=255 for 400 pixels, II_READY=1 -> II_DATA(x,y) = 255*(x+1)*(y+1). Final value 102000 with II_EOF=1. No SOF_ERR.
- Backpressure: random II_READY and PIX_VALID over a gradient frame (gray = x + 20*y via R=G=B) -> every output matches the reference model. II_* stable while stalled. No pixel lost or duplicated.
- Back-to-back frames without SOF -> the second frame restarts at (0,0). The first row of frame 2 excludes frame-1 sums, e.g. white frame 2 gives II_DATA(0,0)=255.
- SOF mid-frame at (7,3) -> SOF_ERR pulses once. That pixel is emitted as (0,0) with y=0 semantics (no line-buffer add).
- Reset asserted mid-row with 2 pixels in flight -> II_VALID=0 and PIX_READY=0 during reset. After release, the next pixel is emitted as (0,0) with its own gray value.
